// File: rtl/bs5_panel_pkg.sv
// Shared definitions for the front-panel subordinate: register addresses, reset values, hex font.
package bs5_panel_pkg;

    localparam logic [1:0] ADDR_DISP = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_LED  = 2'd2;
    localparam logic [1:0] ADDR_SW   = 2'd3;

    localparam logic [15:0] DISP_RST = 16'h0000;
    localparam logic [7:0]  CTRL_RST = 8'hF0;
    localparam logic [15:0] LED_RST  = 16'h0000;
    localparam logic [15:0] SW_RST   = 16'h0000;

    // Active-high segments {g,f,e,d,c,b,a}; the top inverts for the active-low cathodes.
    function automatic logic [6:0] hex_font(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h00;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sub_panel_debounce.sv
// Switch conditioner: 2-flop synchroniser, periodic sampling tick, per-bit two-sample agreement.
// Latency: 2 sync cycles plus 1-2 DEBOUNCE_DIV ticks.
// Backpressure: none; free-running, output always valid.
module sub_panel_debounce #(
    parameter int DEBOUNCE_DIV = 1000000
) (
    input  logic        bus_clock,
    input  logic        reset,
    input  logic [15:0] sw_raw,
    output logic [15:0] sw_clean
);

    localparam int CW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

    logic [15:0]   sync_q1;
    logic [15:0]   sync_q2;
    logic [15:0]   sample_q;
    logic [15:0]   stable;
    logic [CW-1:0] tick_cnt;
    logic          tick;

    assign tick   = (tick_cnt == CW'(DEBOUNCE_DIV - 1));
    // A bit is trusted only if this tick's sample matches the previous tick's sample.
    assign stable = ~(sync_q2 ^ sample_q);

    always_ff @(posedge bus_clock) begin
        if (!reset) begin
            sync_q1  <= '0;
            sync_q2  <= '0;
            sample_q <= '0;
            tick_cnt <= '0;
            sw_clean <= bs5_panel_pkg::SW_RST;
        end else begin
            sync_q1  <= sw_raw;
            sync_q2  <= sync_q1;
            tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
            if (tick) begin
                sample_q <= sync_q2;
                sw_clean <= (sync_q2 & stable) | (sw_clean & ~stable);
            end
        end
    end

endmodule

// File: rtl/sub_bus_rw_panel.sv
// Front-panel bus subordinate: register file, 4-digit 7-seg scan, LEDs, debounced switches.
// Latency: reads 1 cycle after address; writes land at the edge, panel outputs one edge later.
// Backpressure: none; accepts a read and a write every cycle, no wait states.
module sub_bus_rw_panel
    import bs5_panel_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_DIV = 1000000
) (
    input  logic        bus_clock,
    input  logic        reset,
    input  logic        i_bus_we,
    input  logic [1:0]  i_bus_addr,
    input  logic [15:0] i_bus_data_write,
    output logic [15:0] o_bus_data_read,
    input  logic [15:0] i_sw,
    output logic [15:0] o_led,
    output logic [7:0]  o_seg,
    output logic [3:0]  o_an
);

    localparam int SW_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [15:0]   disp_q;
    logic [7:0]    ctrl_q;
    logic [15:0]   led_q;
    logic [15:0]   sw_q;
    logic [SW_W-1:0] slot_cnt;
    logic [1:0]    idx;
    logic          slot_wrap;
    logic [15:0]   rd_mux;
    logic [3:0]    an_nxt;
    logic [7:0]    seg_nxt;
    logic [3:0]    digit_en;
    logic [3:0]    digit_dp;
    logic [3:0]    nibble;

    sub_panel_debounce #(
        .DEBOUNCE_DIV(DEBOUNCE_DIV)
    ) u_debounce (
        .bus_clock(bus_clock),
        .reset    (reset),
        .sw_raw   (i_sw),
        .sw_clean (sw_q)
    );

    assign slot_wrap = (slot_cnt == SW_W'(SCAN_DIV - 1));
    assign digit_dp  = ctrl_q[3:0];
    assign digit_en  = ctrl_q[7:4];
    assign nibble    = disp_q[{idx, 2'b00} +: 4];

    always_comb begin
        rd_mux = 16'h0000;
        case (i_bus_addr)
            ADDR_DISP: rd_mux = disp_q;
            ADDR_CTRL: rd_mux = {8'h00, ctrl_q};
            ADDR_LED:  rd_mux = led_q;
            ADDR_SW:   rd_mux = sw_q;
            default:   rd_mux = 16'h0000;
        endcase
    end

    always_comb begin
        an_nxt  = ~((4'b0001 << idx) & digit_en);
        seg_nxt = 8'hFF;
        if (digit_en[idx]) begin
            seg_nxt = ~{digit_dp[idx], hex_font(nibble)};
        end
    end

    // Register file; the read mux sees pre-write values so same-cycle read returns old data.
    always_ff @(posedge bus_clock) begin
        if (!reset) begin
            disp_q          <= DISP_RST;
            ctrl_q          <= CTRL_RST;
            led_q           <= LED_RST;
            o_bus_data_read <= 16'h0000;
        end else begin
            o_bus_data_read <= rd_mux;
            if (i_bus_we) begin
                case (i_bus_addr)
                    ADDR_DISP: disp_q <= i_bus_data_write;
                    ADDR_CTRL: ctrl_q <= i_bus_data_write[7:0];
                    ADDR_LED:  led_q  <= i_bus_data_write;
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge bus_clock) begin
        if (!reset) begin
            slot_cnt <= '0;
            idx      <= 2'd0;
            o_an     <= 4'hF;
            o_seg    <= 8'hFF;
            o_led    <= 16'h0000;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + SW_W'(1);
            if (slot_wrap) begin
                idx <= idx + 2'd1;
            end
            o_an  <= an_nxt;
            o_seg <= seg_nxt;
            o_led <= led_q;
        end
    end

endmodule

// File: tb/tb_sub_bus_rw_panel.sv
// Scoreboard bench for sub_bus_rw_panel: a cycle model pushes expected outputs, a monitor pops and compares.
module tb_sub_bus_rw_panel;

    localparam int SCAN = 4;
    localparam int DEB  = 8;

    logic        bus_clock = 1'b0;
    logic        rst_n     = 1'b0;
    logic        we        = 1'b0;
    logic [1:0]  addr      = 2'd0;
    logic [15:0] wdat      = 16'h0000;
    logic [15:0] sw        = 16'h0000;
    logic [15:0] o_bus_data_read;
    logic [15:0] o_led;
    logic [7:0]  o_seg;
    logic [3:0]  o_an;

    sub_bus_rw_panel #(
        .SCAN_DIV    (SCAN),
        .DEBOUNCE_DIV(DEB)
    ) dut (
        .bus_clock       (bus_clock),
        .reset           (rst_n),
        .i_bus_we        (we),
        .i_bus_addr      (addr),
        .i_bus_data_write(wdat),
        .o_bus_data_read (o_bus_data_read),
        .i_sw            (sw),
        .o_led           (o_led),
        .o_seg           (o_seg),
        .o_an            (o_an)
    );

    always #5 bus_clock = ~bus_clock;

    typedef struct {
        logic [15:0] rd;
        logic [3:0]  an;
        logic [7:0]  seg;
        logic [15:0] led;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] font_lo [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference state: registers as the CPU sees them, edges since reset release, switch path.
    int          k      = 0;
    logic [15:0] m_disp = 16'h0000;
    logic [7:0]  m_ctrl = 8'hF0;
    logic [15:0] m_led  = 16'h0000;
    logic [15:0] m_sw   = 16'h0000;
    logic [15:0] m_prev = 16'h0000;
    logic [15:0] s1     = 16'h0000;
    logic [15:0] s2     = 16'h0000;

    always @(posedge bus_clock) begin : model
        exp_t        e;
        int          slot;
        logic [15:0] stable;
        logic [15:0] regs [4];
        if (!rst_n) begin
            e.rd = 16'h0000; e.an = 4'hF; e.seg = 8'hFF; e.led = 16'h0000;
            exp_q.push_back(e);
            k = 0; m_disp = 16'h0000; m_ctrl = 8'hF0; m_led = 16'h0000;
            m_sw = 16'h0000; m_prev = 16'h0000; s1 = 16'h0000; s2 = 16'h0000;
        end else begin
            regs[0] = m_disp; regs[1] = {8'h00, m_ctrl}; regs[2] = m_led; regs[3] = m_sw;
            e.rd = regs[addr];
            slot = (k / SCAN) % 4;
            if (m_ctrl[4 + slot]) begin
                e.an  = ~(4'b0001 << slot);
                e.seg = font_lo[m_disp[slot*4 +: 4]];
                if (m_ctrl[slot]) e.seg[7] = 1'b0;
            end else begin
                e.an  = 4'hF;
                e.seg = 8'hFF;
            end
            e.led = m_led;
            exp_q.push_back(e);
            if ((k % DEB) == DEB - 1) begin
                stable = ~(s2 ^ m_prev);
                m_sw   = (s2 & stable) | (m_sw & ~stable);
                m_prev = s2;
            end
            s2 = s1;
            s1 = sw;
            if (we) begin
                case (addr)
                    2'd0: m_disp = wdat;
                    2'd1: m_ctrl = wdat[7:0];
                    2'd2: m_led  = wdat;
                    default: ;
                endcase
            end
            k++;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    always @(negedge bus_clock) begin : monitor
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd",  o_bus_data_read, e.rd);
            check("an",  {12'h000, o_an}, {12'h000, e.an});
            check("seg", {8'h00, o_seg},  {8'h00, e.seg});
            check("led", o_led,           e.led);
        end
    end

    task automatic cyc(input logic w, input logic [1:0] a, input logic [15:0] d);
        we   = w;
        addr = a;
        wdat = d;
        @(posedge bus_clock);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) cyc(1'b0, 2'd0, 16'h0000);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b0, 2'(i), 16'h0000);

        cyc(1'b1, 2'd0, 16'h1A3F);
        repeat (20) cyc(1'b0, 2'd0, 16'h0000);

        cyc(1'b1, 2'd1, 16'hAB52);
        repeat (20) cyc(1'b0, 2'd1, 16'h0000);

        cyc(1'b1, 2'd2, 16'h8001);
        cyc(1'b0, 2'd2, 16'h0000);
        repeat (3) cyc(1'b0, 2'd2, 16'h0000);

        cyc(1'b1, 2'd3, 16'hFFFF);
        cyc(1'b0, 2'd3, 16'h0000);

        sw = 16'hBEEF;
        repeat (30) cyc(1'b0, 2'd3, 16'h0000);
        for (int i = 0; i < 16 && (k % DEB) != 1; i++) cyc(1'b0, 2'd3, 16'h0000);
        sw[0] = ~sw[0];
        repeat (3) cyc(1'b0, 2'd3, 16'h0000);
        sw[0] = ~sw[0];
        repeat (30) cyc(1'b0, 2'd3, 16'h0000);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) sw = 16'($urandom);
            cyc($urandom_range(0, 3) == 0, 2'($urandom), 16'($urandom));
        end

        cyc(1'b1, 2'd1, 16'h00F0);
        cyc(1'b1, 2'd0, 16'h1234);
        for (int i = 0; i < 40 && ((k / SCAN) % 4) != 2; i++) cyc(1'b0, 2'd0, 16'h0000);
        rst_n = 1'b0;
        repeat (3) cyc(1'b0, 2'd0, 16'h0000);
        rst_n = 1'b1;
        repeat (24) cyc(1'b0, 2'd0, 16'h0000);

        #10;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
